instr_fetch_queue: RTL
======================

# instr_fetch_queue

Instruction fetch stage for the 5-stage pipelined processor. It generates the PC, issues word reads to instruction memory, and buffers returned instructions in a small prefetch FIFO. The decode stage drains that FIFO over a valid/ready handshake. A redirect input (branch or jump resolution) flushes everything and restarts fetch at a new PC. The block sits directly upstream of the IF/ID pipeline register and supplies the {IR, NPC} pair it latches.

## Interface
- `DEPTH`, default 4: FIFO entries, power of two, minimum 2.
- `RESET_PC`, default 32'h0: fetch address after reset.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `imem_req` out 1: read request to instruction memory this cycle.
- `imem_addr` out 32: byte address of the request, always word-aligned (bits [1:0] = 0).
- `imem_rdata` in 32: instruction word; valid the cycle after the cycle in which `imem_req` was high (fixed 1-cycle latency, no backpressure).
- `id_valid` out 1: FIFO head holds a valid instruction.
- `id_ir` out 32: head instruction word.
- `id_npc` out 32: head instruction address + 4.
- `id_ready` in 1: decode accepts the head this cycle.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch address; bits [1:0] are ignored and forced to 0.
- `fetched_cnt` out 32: count of completed decode handshakes (`id_valid && id_ready`), wraps modulo 2^32.

## Operation
State:
- `pc`: 32-bit fetch address.
- `inflight`: 1 bit, a request was issued last cycle.
- FIFO storage: `DEPTH` × {ir[31:0], npc[31:0]}, with read/write pointers and `count` (0..DEPTH).
- `fetched_cnt`.

Issue (combinational):
- `imem_req` = !redirect_valid && (count + inflight < DEPTH).
- `imem_addr` = `pc`.
- Pops in the current cycle give no credit to the issue check. This is conservative; the FIFO can never overflow.

Each rising edge:
- If `imem_req`: `pc` <= `pc` + 4 (wraps 32'hFFFFFFFC → 0) and `inflight` <= 1. Otherwise `inflight` <= 0.
- Response push: if `inflight && !redirect_valid`, push {`imem_rdata`, addr_of_request + 4}. The block holds the request address in a 32-bit register.
- Pop: if `id_valid && id_ready`, advance the read pointer and increment `fetched_cnt`.
- Push and pop in the same cycle: `count` is unchanged, both pointers advance.
- Redirect (`redirect_valid` = 1):
  - Any handshake on the head this cycle completes normally and is counted.
  - All other FIFO contents are discarded and `count` <= 0.
  - The in-flight response arriving this cycle is dropped.
  - `pc` <= {`redirect_pc`[31:2], 2'b00} and `inflight` <= 0.
  - No request is issued this cycle.
- Outputs:
  - `id_valid` = (count != 0).
  - `id_ir` and `id_npc` come directly from the head entry. They are stable while `id_valid && !id_ready`.
  - When `count` = 0, `id_ir`/`id_npc` are don't-care but never X after reset (storage is reset to 0).

## Timing
- Values during and after reset:
  - `pc` = `RESET_PC`, `count` = 0, `inflight` = 0, pointers = 0, storage = 0, `fetched_cnt` = 0.
  - `id_valid` = 0, `id_ir` = 0, `id_npc` = 0.
  - `imem_req` is 1 combinationally once reset deasserts (count + inflight = 0 < DEPTH).
- Latency:
  - Request issued in cycle N, data sampled in cycle N+1, `id_valid` high in cycle N+2.
  - First instruction reaches decode in the 2nd cycle after reset release.
- Throughput: 1 instruction/cycle sustained when `id_ready` is held at 1.
- Full FIFO:
  - With `id_ready` = 0, at most `DEPTH` entries are ever held.
  - `imem_req` drops once count + inflight = DEPTH.
  - It reasserts the cycle after the first pop.
- Redirect to first valid:
  - Redirect in cycle R, request at `redirect_pc` in R+1, `id_valid` in R+3.
  - `id_valid` = 0 in cycles R+1 and R+2.
- Back-to-back redirects: the last one wins, and no request issues while `redirect_valid` is held.
- Reset asserted mid-operation discards everything asynchronously, including the in-flight response.

## Test plan
- Free run: memory returns word = addr, `id_ready` = 1. Required: `id_ir` = 0, 4, 8, … with `id_npc` = 4, 8, 12, …, first `id_valid` in cycle 2, one instruction per cycle after that.
- Stall: `id_ready` = 0 for 10 cycles. Required: exactly 4 requests (addr 0..12), `imem_req` then 0, count = 4. Then `id_ready` = 1: head 0, 4, 8, 12, 16 in order, no duplicates or gaps.
- Redirect while full: `redirect_pc` = 32'h40 with count = 4 and a request in flight. Required: `id_valid` = 0 for 2 cycles, next request addr 0x40, first delivered `id_ir` = 0x40 with `id_npc` = 0x44.
- Redirect with a concurrent handshake: `id_valid` = `id_ready` = `redirect_valid` = 1. Required: `fetched_cnt` increments by 1 and all remaining entries are dropped.
- Alignment and wrap: `redirect_pc` = 32'hFFFFFFFF. Required: `imem_addr` = 32'hFFFFFFFC with `id_npc` = 0, and the next request is at addr 0.
- Async reset mid-stream: assert `reset` between clock edges with count = 3. Required: `id_valid` = 0 and `fetched_cnt` = 0 immediately; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: PC generation, fixed-latency instruction memory
// requests, and a small prefetch FIFO drained by decode over valid/ready.
// A redirect flushes queued and in-flight instructions and restarts fetch.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_ir,
  output logic [31:0] id_npc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetched_cnt
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   ir_q [DEPTH];
  logic [31:0]   ir_d [DEPTH];
  logic [31:0]   npc_q [DEPTH];
  logic [31:0]   npc_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetched_q, fetched_d;

  logic [CW:0]   occupancy_s;
  logic          req_s;
  logic          push_s;
  logic          pop_s;

  // Issue decision: queued plus outstanding must leave room; pops earn no credit
  always_comb begin
    occupancy_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    req_s       = !redirect_valid && (occupancy_s < DEPTH_W);
    push_s      = inflight_q && !redirect_valid;
    pop_s       = (count_q != {CW{1'b0}}) && id_ready;
  end

  // Next-state for PC, in-flight tracking, FIFO storage/pointers and counter
  always_comb begin
    pc_d       = pc_q;
    inflight_d = 1'b0;
    req_addr_d = req_addr_q;
    ir_d       = ir_q;
    npc_d      = npc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetched_d  = fetched_q;

    // Low two address bits of the redirect target are masked off here
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (req_s) begin
      pc_d       = pc_q + 32'd4;
      inflight_d = 1'b1;
      req_addr_d = pc_q;
    end else begin
      pc_d = pc_q;
    end

    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      fetched_d = fetched_q + 32'd1;
    end else begin
      rd_ptr_d  = rd_ptr_q;
    end

    if (push_s) begin
      ir_d[wr_ptr_q]  = imem_rdata;
      npc_d[wr_ptr_q] = req_addr_q + 32'd4;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // A redirect empties the queue after any head handshake has been counted
    if (redirect_valid) begin
      count_d  = {CW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear of everything, storage included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      req_addr_q <= 32'h0000_0000;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      fetched_q  <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= 32'h0000_0000;
        npc_q[i] <= 32'h0000_0000;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fetched_q  <= fetched_d;
      ir_q       <= ir_d;
      npc_q      <= npc_d;
    end
  end

  // Output mapping: head entry feeds decode directly
  always_comb begin
    imem_req    = req_s;
    imem_addr   = pc_q;
    id_valid    = (count_q != {CW{1'b0}});
    id_ir       = ir_q[rd_ptr_q];
    id_npc      = npc_q[rd_ptr_q];
    fetched_cnt = fetched_q;
  end

endmodule
